// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI-Stream packet cache.
//   mode_e      : STREAM (cut-through) or PACKET (store-and-forward)
//   count_width : width of a counter that must hold 0..depth inclusive
package axi_stream_pkg;

  typedef enum logic {
    STREAM = 1'b0,
    PACKET = 1'b1
  } mode_e;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axi_stream_inf.sv
// AXI-Stream bundle with a per-side clock enable.
//   master : drives tvalid/tdata/tlast, samples tready/aclken
//   slaver : samples tvalid/tdata/tlast/aclken, drives tready
// A beat moves only in a cycle where tvalid && tready && aclken are all high.
interface axi_stream_inf #(
  parameter int DSIZE = 64
) ();

  logic             tvalid;
  logic             tready;
  logic [DSIZE-1:0] tdata;
  logic             tlast;
  logic             aclken;

  modport master (output tvalid, output tdata, output tlast, input tready, input aclken);
  modport slaver (input tvalid, input tdata, input tlast, input aclken, output tready);

endinterface

// File: rtl/axi_stream_cache_ram.sv
// Simple dual-port storage for the packet cache.
//   clk   : write clock
//   we    : write enable, waddr/wdata : write port
//   raddr : read address, rdata : asynchronous read data (gives FWFT head)
module axi_stream_cache_ram #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_stream_packet_cache.sv
// AXI-Stream packet cache: FWFT beat buffer with cut-through (STREAM) or
// store-and-forward (PACKET) release of stored data.
//   aclk, rst    : clock, synchronous active-high reset
//   axis_in      : upstream stream (slaver side), tready = !full
//   axis_out     : downstream stream (master side), head beat presented FWFT
//   count        : beats stored
//   pkt_count    : complete packets (tlast beats) stored
//   almost_full  : count >= DEPTH-AF_OFFSET
//   almost_empty : count <= AE_OFFSET
//
// Handshake: a write happens when axis_in.tvalid && axis_in.tready &&
// axis_in.aclken; a read when axis_out.tvalid && axis_out.tready &&
// axis_out.aclken. tready/tvalid depend only on stored state, never on the
// partner's valid/ready, and the head beat is stable until it is read.
module axi_stream_packet_cache
  import axi_stream_pkg::*;
#(
  parameter int DSIZE     = 64,
  parameter int DEPTH     = 512,
  parameter     MODE      = "STREAM",
  parameter int AF_OFFSET = 16,
  parameter int AE_OFFSET = 16
) (
  input  logic                          aclk,
  input  logic                          rst,
  axi_stream_inf.slaver                 axis_in,
  axi_stream_inf.master                 axis_out,
  output logic [count_width(DEPTH)-1:0] count,
  output logic [count_width(DEPTH)-1:0] pkt_count,
  output logic                          almost_full,
  output logic                          almost_empty
);

  localparam int    AW       = $clog2(DEPTH);
  localparam int    CW       = count_width(DEPTH);
  localparam mode_e MODE_SEL = (MODE == "PACKET") ? PACKET : STREAM;

  // Thresholds are clamped into 0..DEPTH so they always fit the counter.
  localparam int AF_TH = (AF_OFFSET > DEPTH) ? 0 : DEPTH - AF_OFFSET;
  localparam int AE_TH = (AE_OFFSET > DEPTH) ? DEPTH : AE_OFFSET;

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_TH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_TH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] pkt_q;
  logic          release_q;

  logic          full;
  logic          out_valid;
  logic          wr_en;
  logic          rd_en;
  logic          wr_last;
  logic          rd_last;
  logic [DSIZE:0] wr_word;
  logic [DSIZE:0] rd_word;

  assign full = (count_q == FULL_LVL);

  // In PACKET mode data is held back until a whole packet is stored, unless
  // the buffer filled up with no tlast in it: release then lets an oversized
  // packet stream out instead of deadlocking.
  assign out_valid = (count_q != '0) &&
                     ((MODE_SEL == STREAM) || (pkt_q != '0) || release_q);

  assign wr_en   = axis_in.tvalid && !full && axis_in.aclken;
  assign rd_en   = out_valid && axis_out.tready && axis_out.aclken;
  assign wr_last = wr_en && axis_in.tlast;
  assign rd_last = rd_en && rd_word[DSIZE];

  assign wr_word = {axis_in.tlast, axis_in.tdata};

  axi_stream_cache_ram #(
    .WIDTH (DSIZE + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (aclk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  always_ff @(posedge aclk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      pkt_q     <= '0;
      release_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (wr_en && !rd_en) begin
        count_q <= count_q + 1'b1;
      end else if (!wr_en && rd_en) begin
        count_q <= count_q - 1'b1;
      end

      if (wr_last && !rd_last) begin
        pkt_q <= pkt_q + 1'b1;
      end else if (!wr_last && rd_last) begin
        pkt_q <= pkt_q - 1'b1;
      end

      // Reading the tlast of the oversized packet ends the release window.
      if (rd_last) begin
        release_q <= 1'b0;
      end else if ((MODE_SEL == PACKET) && full && (pkt_q == '0)) begin
        release_q <= 1'b1;
      end
    end
  end

  assign axis_in.tready  = !full;
  assign axis_out.tvalid = out_valid;
  assign axis_out.tdata  = rd_word[DSIZE-1:0];
  assign axis_out.tlast  = rd_word[DSIZE];

  assign count        = count_q;
  assign pkt_count    = pkt_q;
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);

endmodule

// File: tb/tb_axi_stream_packet_cache.sv
// Bench for axi_stream_packet_cache: one STREAM and one PACKET instance,
// both DEPTH=16, AF_OFFSET=4, AE_OFFSET=4, checked every cycle against a
// queue-based reference of the buffer contents.
module tb_axi_stream_packet_cache;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int AF_TH = 12;
  localparam int AE_TH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_stream_inf #(.DSIZE(DW)) s_in  ();
  axi_stream_inf #(.DSIZE(DW)) s_out ();
  axi_stream_inf #(.DSIZE(DW)) p_in  ();
  axi_stream_inf #(.DSIZE(DW)) p_out ();

  logic [CW-1:0] s_count, s_pkt_count, p_count, p_pkt_count;
  logic          s_af, s_ae, p_af, p_ae;

  axi_stream_packet_cache #(
    .DSIZE(DW), .DEPTH(DEPTH), .MODE("STREAM"), .AF_OFFSET(4), .AE_OFFSET(4)
  ) u_str (
    .aclk(clk), .rst(rst), .axis_in(s_in), .axis_out(s_out),
    .count(s_count), .pkt_count(s_pkt_count),
    .almost_full(s_af), .almost_empty(s_ae)
  );

  axi_stream_packet_cache #(
    .DSIZE(DW), .DEPTH(DEPTH), .MODE("PACKET"), .AF_OFFSET(4), .AE_OFFSET(4)
  ) u_pkt (
    .aclk(clk), .rst(rst), .axis_in(p_in), .axis_out(p_out),
    .count(p_count), .pkt_count(p_pkt_count),
    .almost_full(p_af), .almost_empty(p_ae)
  );

  // ---------------- reference model / scoreboard ----------------
  int errors = 0;
  int checks = 0;

  logic [DW:0]   s_exp_q[$];
  logic [DW:0]   p_exp_q[$];
  int            s_left = 0;       // beats still to send; tlast on the last one
  int            p_left = 0;
  logic [DW-1:0] s_wval = '0;      // next value to send
  logic [DW-1:0] s_rval = '0;      // next value expected out
  logic [DW-1:0] p_wval = '0;
  logic [DW-1:0] p_rval = '0;
  int            s_pkts = 0;
  int            p_pkts = 0;
  bit            p_rel  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit p_vis();
    return (p_exp_q.size() != 0) && ((p_pkts != 0) || p_rel);
  endfunction

  task automatic check_all();
    check("s_count", 32'(s_count), 32'(s_exp_q.size()));
    check("s_pkt_count", 32'(s_pkt_count), 32'(s_pkts));
    check("s_tvalid", 32'(s_out.tvalid), 32'(s_exp_q.size() != 0));
    check("s_tready", 32'(s_in.tready), 32'(s_exp_q.size() < DEPTH));
    check("s_af", 32'(s_af), 32'(s_exp_q.size() >= AF_TH));
    check("s_ae", 32'(s_ae), 32'(s_exp_q.size() <= AE_TH));
    if (s_exp_q.size() != 0) check("s_head", 32'({s_out.tlast, s_out.tdata}), 32'(s_exp_q[0]));
    check("p_count", 32'(p_count), 32'(p_exp_q.size()));
    check("p_pkt_count", 32'(p_pkt_count), 32'(p_pkts));
    check("p_tvalid", 32'(p_out.tvalid), 32'(p_vis()));
    check("p_tready", 32'(p_in.tready), 32'(p_exp_q.size() < DEPTH));
    check("p_af", 32'(p_af), 32'(p_exp_q.size() >= AF_TH));
    check("p_ae", 32'(p_ae), 32'(p_exp_q.size() <= AE_TH));
    check("p_release", 32'(u_pkt.release_q), 32'(p_rel));
    if (p_vis()) check("p_head", 32'({p_out.tlast, p_out.tdata}), 32'(p_exp_q[0]));
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    bit          s_w, s_r, p_w, p_r, p_set, p_rd_last;
    logic [DW:0] s_got, p_got;
    s_in.tvalid = (s_left > 0);
    s_in.tdata  = s_wval;
    s_in.tlast  = (s_left == 1);
    p_in.tvalid = (p_left > 0);
    p_in.tdata  = p_wval;
    p_in.tlast  = (p_left == 1);
    s_w   = !rst && s_in.tvalid && s_in.aclken && (s_exp_q.size() < DEPTH);
    s_r   = !rst && (s_exp_q.size() != 0) && s_out.tready && s_out.aclken;
    p_w   = !rst && p_in.tvalid && p_in.aclken && (p_exp_q.size() < DEPTH);
    p_r   = !rst && p_vis() && p_out.tready && p_out.aclken;
    p_set = (p_exp_q.size() == DEPTH) && (p_pkts == 0);
    p_rd_last = p_r && p_exp_q[0][DW];
    s_got = {s_out.tlast, s_out.tdata};
    p_got = {p_out.tlast, p_out.tdata};
    @(posedge clk);
    #1;
    if (rst) begin
      s_exp_q.delete();
      p_exp_q.delete();
      s_pkts = 0;
      p_pkts = 0;
      p_rel  = 1'b0;
      s_rval = s_wval;
      p_rval = p_wval;
    end else begin
      if (s_r) begin
        check("s_order", 32'(s_got[DW-1:0]), 32'(s_rval));
        if (s_exp_q[0][DW]) s_pkts--;
        void'(s_exp_q.pop_front());
        s_rval = s_rval + 1'b1;
      end
      if (s_w) begin
        s_exp_q.push_back({s_in.tlast, s_in.tdata});
        if (s_in.tlast) s_pkts++;
        s_wval = s_wval + 1'b1;
        s_left--;
      end
      if (p_r) begin
        check("p_order", 32'(p_got[DW-1:0]), 32'(p_rval));
        void'(p_exp_q.pop_front());
        p_rval = p_rval + 1'b1;
      end
      if (p_rd_last) p_pkts--;
      if (p_w) begin
        p_exp_q.push_back({p_in.tlast, p_in.tdata});
        if (p_in.tlast) p_pkts++;
        p_wval = p_wval + 1'b1;
        p_left--;
      end
      if (p_rd_last) p_rel = 1'b0;
      else if (p_set) p_rel = 1'b1;
    end
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Bounded drain of both instances with both sides fully enabled.
  task automatic drain(input int bound);
    int n;
    n = 0;
    s_in.aclken = 1'b1;  s_out.aclken = 1'b1;  s_out.tready = 1'b1;
    p_in.aclken = 1'b1;  p_out.aclken = 1'b1;  p_out.tready = 1'b1;
    while ((s_exp_q.size() != 0 || p_exp_q.size() != 0 || s_left > 0 || p_left > 0) && n < bound) begin
      tick();
      n++;
    end
    check("drain_done", 32'(s_exp_q.size() + p_exp_q.size() + s_left + p_left), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] start_w;
    logic [DW-1:0] start_r;

    s_in.aclken = 1'b1;  s_out.aclken = 1'b1;  s_out.tready = 1'b0;
    p_in.aclken = 1'b1;  p_out.aclken = 1'b1;  p_out.tready = 1'b0;

    // Reset with transfers presented: they must be ignored.
    rst = 1'b1;
    s_left = 3;
    p_left = 3;
    run(2);
    rst = 1'b0;
    s_left = 0;
    p_left = 0;
    check("rst_s_tvalid", 32'(s_out.tvalid), 32'd0);
    check("rst_s_tready", 32'(s_in.tready), 32'd1);
    check("rst_s_ae", 32'(s_ae), 32'd1);
    check("rst_s_af", 32'(s_af), 32'd0);
    check("rst_p_count", 32'(p_count), 32'd0);

    // STREAM fill to full, blocked write, then in-order drain.
    s_left = 16;
    run(16);
    check("fill_s_tready", 32'(s_in.tready), 32'd0);
    check("fill_s_count", 32'(s_count), 32'd16);
    check("fill_s_af", 32'(s_af), 32'd1);
    s_left = 1;
    run(1);
    check("blocked_s_count", 32'(s_count), 32'd16);
    s_left = 0;
    drain(40);
    check("fill_s_drained", 32'(s_rval), 32'd16);

    // PACKET: a 5-beat packet stays invisible until its tlast is stored.
    p_out.tready = 1'b0;
    p_left = 5;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pkt5_hidden", 32'(p_out.tvalid), 32'd0);
    end
    tick();
    check("pkt5_visible", 32'(p_out.tvalid), 32'd1);
    check("pkt5_pkt_count", 32'(p_pkt_count), 32'd1);
    drain(20);

    // PACKET: 20-beat packet forces release after the buffer fills.
    p_out.tready = 1'b0;
    start_r = p_rval;
    p_left = 20;
    run(16);
    tick();
    check("big_release_set", 32'(u_pkt.release_q), 32'd1);
    check("big_tvalid", 32'(p_out.tvalid), 32'd1);
    drain(80);
    check("big_release_clr", 32'(u_pkt.release_q), 32'd0);
    check("big_delivered", 32'(p_rval - start_r), 32'd20);

    // STREAM: steady read+write at count 7 across the pointer wrap.
    s_out.tready = 1'b0;
    s_left = 10;
    run(10);
    drain(30);
    s_out.tready = 1'b0;
    s_left = 7;
    run(7);
    check("rw_start_count", 32'(s_count), 32'd7);
    s_out.tready = 1'b1;
    s_left = 10;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rw_count", 32'(s_count), 32'd7);
    end
    drain(30);

    // PACKET: reset with two complete packets stored.
    p_out.tready = 1'b0;
    p_left = 4;
    run(4);
    p_left = 5;
    run(5);
    check("pre_rst_count", 32'(p_count), 32'd9);
    check("pre_rst_pkts", 32'(p_pkt_count), 32'd2);
    rst = 1'b1;
    s_left = 2;
    p_left = 2;
    tick();
    rst = 1'b0;
    s_left = 0;
    p_left = 0;
    check("mid_rst_count", 32'(p_count), 32'd0);
    check("mid_rst_pkts", 32'(p_pkt_count), 32'd0);
    check("mid_rst_tvalid", 32'(p_out.tvalid), 32'd0);
    check("mid_rst_tready", 32'(p_in.tready), 32'd1);

    // Random clock enables with valid/ready held high.
    start_w = s_wval;
    s_out.tready = 1'b1;
    p_out.tready = 1'b1;
    s_left = 80;
    for (int i = 0; i < 200; i++) begin
      s_in.aclken  = 1'($urandom_range(0, 1));
      s_out.aclken = 1'($urandom_range(0, 1));
      p_in.aclken  = 1'($urandom_range(0, 1));
      p_out.aclken = 1'($urandom_range(0, 1));
      if (p_left == 0 && i < 150) p_left = $urandom_range(1, 6);
      tick();
    end
    drain(200);
    check("rnd_s_sent", 32'(s_wval - start_w), 32'd80);
    check("rnd_s_no_loss", 32'(s_rval), 32'(s_wval));
    check("rnd_p_no_loss", 32'(p_rval), 32'(p_wval));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_stream_packet_cache.md
AXI_STREAM_PACKET_CACHE -- requirements
Module: axi_stream_packet_cache

Interface
REQ-001 Parameter DSIZE, default 64: tdata width in bits, 1..1024.
REQ-002 Parameter DEPTH, default 512: storage depth in beats, power of two, 4..4096.
REQ-003 Parameter MODE, default "STREAM": "STREAM" is cut-through; "PACKET" is store-and-forward.
REQ-004 Parameter AF_OFFSET, default 16: almost_full threshold offset; AE_OFFSET, default 16: almost_empty threshold offset.
REQ-005 Port aclk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst, input, 1: reset; synchronous, active-high.
REQ-007 Port axis_in (axi_stream_inf.slaver), input side: SHALL use tvalid, tdata[DSIZE-1:0], tlast and aclken, and drive tready.
REQ-008 Port axis_out (axi_stream_inf.master), output side: SHALL drive tvalid, tdata[DSIZE-1:0] and tlast, and use tready and aclken.
REQ-009 Port count, output, $clog2(DEPTH)+1: number of beats stored.
REQ-010 Port pkt_count, output, $clog2(DEPTH)+1: number of complete packets (tlast stored) held.
REQ-011 Port almost_full, output, 1: asserted when count >= DEPTH-AF_OFFSET.
REQ-012 Port almost_empty, output, 1: asserted when count <= AE_OFFSET.

Function
REQ-013 A write SHALL occur when axis_in.tvalid && axis_in.tready && axis_in.aclken; a read SHALL occur when axis_out.tvalid && axis_out.tready && axis_out.aclken.
REQ-014 axis_in.tready SHALL be !full, where full is count==DEPTH; it is independent of axis_in.tvalid.
REQ-015 Storage SHALL be first-word-fall-through: head beat {tlast,tdata} is presented on axis_out while tvalid is high.
REQ-016 In STREAM mode, axis_out.tvalid SHALL be count!=0; a beat written in cycle N SHALL be readable in cycle N+1.
REQ-017 In PACKET mode, axis_out.tvalid SHALL be (count!=0) && (pkt_count!=0 || release).
REQ-018 In PACKET mode, a tlast beat written in cycle N SHALL make its packet visible in cycle N+1.
REQ-019 In PACKET mode, release SHALL set when full && pkt_count==0, which prevents deadlock on packets longer than DEPTH. Release SHALL clear after a read of a tlast beat.
REQ-020 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH without gaps.
REQ-021 count update: +1 on write only, -1 on read only, unchanged on simultaneous read and write.
REQ-022 pkt_count update: +1 on a tlast write, -1 on a tlast read, unchanged when both occur in one cycle.
REQ-023 Read and write when count==0: not possible, because tvalid is low.
REQ-024 Read and write when full: the write is blocked that cycle; the read proceeds.
REQ-025 When aclken is low on a side, that side SHALL perform no transfer and its pointers SHALL hold.
REQ-026 axis_out.tdata and tlast SHALL hold stable while tvalid && !tready.

Reset
REQ-027 On rst high at a clock edge, pointers, count, pkt_count and release SHALL go to 0.
REQ-028 The cycle after reset, outputs SHALL be: axis_out.tvalid=0, axis_in.tready=1, almost_empty=1, almost_full=0.
REQ-029 Reset mid-packet SHALL discard all stored data, including partial packets; memory contents need not clear.
REQ-030 Transfers presented during the rst cycle SHALL be ignored.

Structure
REQ-031 Shared package axi_stream_pkg SHALL hold the mode enum (STREAM, PACKET) and a function returning the count width for a given DEPTH.
REQ-032 One sub-module, axi_stream_cache_ram, SHALL be a simple dual-port RAM of DEPTH x (DSIZE+1) with async read for FWFT; all control SHALL stay in the top.

Verification
REQ-033 STREAM, DEPTH=16: write beats 0..15 with tready_out=0 -> in.tready=0 after the 16th, count=16, almost_full=1 (AF_OFFSET=4); then drain -> data out 0..15 in order.
REQ-034 PACKET, DEPTH=16: write 5 beats with tlast on beat 5 only -> out.tvalid=0 through beat 4 and 1 in the cycle after beat 5; pkt_count=1.
REQ-035 PACKET, DEPTH=16: a 20-beat packet -> after 16 writes release=1; out.tvalid=1; all 20 beats are delivered in order; release=0 after the tlast read.
REQ-036 Simultaneous read and write at count=7 for 10 cycles -> count stays 7; wrap-around past index 15 corrupts no data.
REQ-037 Reset asserted at count=9, pkt_count=2 -> next cycle count=0, pkt_count=0, out.tvalid=0, in.tready=1.
REQ-038 Toggle axis_in.aclken and axis_out.aclken randomly with tvalid/tready held high -> beats transfer only on aclken cycles; the scoreboard shows no loss or duplication.
